// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage Wishbone classic bus master.
//
// Takes the EX/MEM control fields and runs one single-beat Wishbone cycle for
// each load or store. While that cycle is in flight it asks the hazard
// controller to stall. Load data is returned sign-extended for LB and
// unchanged for LW.
//
// Ports:
//   clk, reset         pipeline clock; asynchronous active-high reset
//   MemRead, MemWrite  load / store request (both high = store)
//   MemSize            1 = 32-bit word access, 0 = 8-bit byte access
//   addr, wdata        byte address and store data from EX/MEM
//   advance            EX/MEM loads a new instruction at this edge
//   mem_stall          stall request (combinational)
//   load_data          load result for MEM/WB (registered)
//   wb_*               Wishbone classic master interface (registered outputs)
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MemSize,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  advance,
  output logic                  mem_stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r;
  logic        req_s;
  logic        mem_stall_s;
  // Lane and size of the access in flight. The load result is built from
  // these copies, not from the live EX/MEM fields.
  logic [1:0]  lane_r;
  logic        word_r;

  // Byte-lane select for a word access or a single byte lane.
  function automatic logic [3:0] lane_sel(input logic word, input logic [1:0] lane);
    logic [3:0] sel;
    if (word) begin
      sel = 4'b1111;
    end else begin
      sel = 4'b0001 << lane;
    end
    return sel;
  endfunction

  // Load result: the full word, or the selected byte sign-extended (LB).
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic                  word,
    input logic [1:0]            lane,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [7:0]            b;
    logic [DATA_WIDTH-1:0] res;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = d[7:0];
    endcase
    if (word) begin
      res = d;
    end else begin
      res = {{(DATA_WIDTH-8){b[7]}}, b};
    end
    return res;
  endfunction

  assign req_s     = MemRead | MemWrite;
  assign mem_stall = mem_stall_s;

  // Stall request: the IDLE cycle of a memory instruction plus every BUSY
  // cycle. It is forced low while reset is asserted.
  always_comb begin
    mem_stall_s = 1'b0;
    if (reset) begin
      mem_stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    mem_stall_s = req_s;
        BUSY:    mem_stall_s = 1'b1;
        DONE:    mem_stall_s = 1'b0;
        default: mem_stall_s = 1'b0;
      endcase
    end
  end

  // Bus FSM: issue in IDLE, wait for ack in BUSY, and hold in DONE until
  // EX/MEM advances so that the same instruction is not issued twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= 4'b0000;
      load_data <= '0;
      lane_r    <= 2'b00;
      word_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            wb_adr_o <= {addr[ADDR_WIDTH-1:2], 2'b00};
            wb_we_o  <= MemWrite;
            wb_sel_o <= lane_sel(MemSize, addr[1:0]);
            wb_dat_o <= MemSize ? wdata : {(DATA_WIDTH/8){wdata[7:0]}};
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            lane_r   <= addr[1:0];
            word_r   <= MemSize;
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (!wb_we_o) begin
              load_data <= load_extract(word_r, lane_r, wb_dat_i);
            end
            state_r <= DONE;
          end
        end
        DONE: begin
          if (advance) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It uses directed scenarios, and every
// expected value is computed by hand.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic        MemSize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        advance;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int checks = 0;
  int errors = 0;

  // Values observed during the most recent run_access call.
  int          n_stall;
  int          n_cyc;
  logic [31:0] seen_adr;
  logic [31:0] seen_dat;
  logic [3:0]  seen_sel;
  logic        seen_we;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemSize   (MemSize),
    .addr      (addr),
    .wdata     (wdata),
    .advance   (advance),
    .mem_stall (mem_stall),
    .load_data (load_data),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access from IDLE. The slave acks during the k-th BUSY cycle.
  // The task returns in DONE, 1 ns after the completing edge.
  task automatic run_access(input logic rd, input logic wr, input logic sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int k);
    MemRead = rd; MemWrite = wr; MemSize = sz; addr = a; wdata = wd;
    n_stall = 0; n_cyc = 0;
    #1;
    if (mem_stall) n_stall++;
    if (wb_cyc_o) n_cyc++;
    tick();
    for (int i = 1; i <= k; i++) begin
      if (i == 1) begin
        seen_adr = wb_adr_o; seen_dat = wb_dat_o; seen_sel = wb_sel_o; seen_we = wb_we_o;
      end
      if (i == k) begin
        wb_ack_i = 1'b1; wb_dat_i = rdat;
      end
      #1;
      if (mem_stall) n_stall++;
      if (wb_cyc_o && wb_stb_o) n_cyc++;
      tick();
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    end
  endtask

  task automatic finish_insn();
    advance = 1'b1;
    tick();
    advance = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    MemRead = 1'b1; MemSize = 1'b1; addr = 32'h0000_0004;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", mem_stall); end
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b exp 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    checks++; if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0 || load_data !== 32'h0) begin
      errors++; $display("FAIL rst_data got adr %h dat %h sel %h ld %h exp all 0", wb_adr_o, wb_dat_o, wb_sel_o, load_data);
    end
    MemRead = 1'b0;
    tick();
    reset = 1'b0;
    // Byte load of 0xFF from lane 0, so that load_data is nonzero before the mid-cycle reset.
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_00FF, 1);
    checks++; if (load_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pre_rst_load got %h exp ffffffff", load_data); end
    finish_insn();
    MemRead = 1'b1; MemSize = 1'b1; addr = 32'h0000_0004;
    tick();
    checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL busy_cyc got %0h exp 1", wb_cyc_o); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, mem_stall} !== 3'b000) begin errors++; $display("FAIL async_rst got %b exp 000", {wb_cyc_o, wb_stb_o, mem_stall}); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_load got %h exp 0", load_data); end
    MemRead = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0;
    tick();
    checks++; if ({wb_cyc_o, mem_stall} !== 2'b00 || load_data !== 32'h0) begin
      errors++; $display("FAIL late_ack got cyc %0h stall %0h ld %h exp 0 0 0", wb_cyc_o, mem_stall, load_data);
    end
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
  endtask

  task automatic test_word_load();
    run_access(1'b1, 1'b0, 1'b1, 32'h8000_0006, 32'h0, 32'hDEAD_BEEF, 2);
    checks++; if (seen_adr !== 32'h8000_0004) begin errors++; $display("FAIL wl_adr got %h exp 80000004", seen_adr); end
    checks++; if (seen_sel !== 4'b1111 || seen_we !== 1'b0) begin errors++; $display("FAIL wl_sel_we got %b %b exp 1111 0", seen_sel, seen_we); end
    checks++; if (n_stall != 3 || n_cyc != 2) begin errors++; $display("FAIL wl_timing got stall %0d cyc %0d exp 3 2", n_stall, n_cyc); end
    checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wl_data got %h exp deadbeef", load_data); end
    checks++; if ({wb_cyc_o, wb_stb_o, mem_stall} !== 3'b000) begin errors++; $display("FAIL wl_done got %b exp 000", {wb_cyc_o, wb_stb_o, mem_stall}); end
    finish_insn();
  endtask

  task automatic test_byte_load();
    run_access(1'b1, 1'b0, 1'b0, 32'h1000_0003, 32'h0, 32'h80FF_0011, 1);
    checks++; if (seen_sel !== 4'b1000 || seen_adr !== 32'h1000_0000) begin errors++; $display("FAIL bl_sel got %b %h exp 1000 10000000", seen_sel, seen_adr); end
    checks++; if (load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL bl_neg got %h exp ffffff80", load_data); end
    finish_insn();
    run_access(1'b1, 1'b0, 1'b0, 32'h1000_0003, 32'h0, 32'h7F00_0000, 1);
    checks++; if (load_data !== 32'h0000_007F) begin errors++; $display("FAIL bl_pos got %h exp 0000007f", load_data); end
    finish_insn();
  endtask

  task automatic test_byte_store();
    run_access(1'b0, 1'b1, 1'b0, 32'h1000_0001, 32'h1234_56AB, 32'hFFFF_FFFF, 1);
    checks++; if (seen_we !== 1'b1 || seen_sel !== 4'b0010) begin errors++; $display("FAIL bs_we_sel got %b %b exp 1 0010", seen_we, seen_sel); end
    checks++; if (seen_dat !== 32'hABAB_ABAB) begin errors++; $display("FAIL bs_dat got %h exp abababab", seen_dat); end
    checks++; if (load_data !== 32'h0000_007F) begin errors++; $display("FAIL bs_load got %h exp 0000007f", load_data); end
    finish_insn();
  endtask

  task automatic test_hold_done();
    run_access(1'b1, 1'b0, 1'b1, 32'h3000_0000, 32'h0, 32'h1122_3344, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({wb_cyc_o, mem_stall} !== 2'b00) begin errors++; $display("FAIL hold_%0d got cyc %0h stall %0h exp 0 0", i, wb_cyc_o, mem_stall); end
    end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    run_access(1'b0, 1'b1, 1'b1, 32'h2000_0008, 32'hCAFE_F00D, 32'h0, 1);
    checks++; if (n_cyc != 1 || n_stall != 2) begin errors++; $display("FAIL b2b_timing got cyc %0d stall %0d exp 1 2", n_cyc, n_stall); end
    checks++; if (seen_we !== 1'b1 || seen_sel !== 4'b1111 || seen_dat !== 32'hCAFE_F00D || seen_adr !== 32'h2000_0008) begin
      errors++; $display("FAIL b2b_bus got we %b sel %b dat %h adr %h exp 1 1111 cafef00d 20000008", seen_we, seen_sel, seen_dat, seen_adr);
    end
    checks++; if (load_data !== 32'h1122_3344) begin errors++; $display("FAIL b2b_load got %h exp 11223344", load_data); end
    tick();
    checks++; if ({wb_cyc_o, mem_stall} !== 2'b00) begin errors++; $display("FAIL b2b_done got cyc %0h stall %0h exp 0 0", wb_cyc_o, mem_stall); end
    finish_insn();
  endtask

  task automatic test_rw_and_idle_ack();
    run_access(1'b1, 1'b1, 1'b1, 32'h4000_0010, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1);
    checks++; if (seen_we !== 1'b1 || n_stall != 2) begin errors++; $display("FAIL rw_we got we %b stall %0d exp 1 2", seen_we, n_stall); end
    checks++; if (load_data !== 32'h1122_3344) begin errors++; $display("FAIL rw_load got %h exp 11223344", load_data); end
    finish_insn();
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({wb_cyc_o, mem_stall} !== 2'b00 || load_data !== 32'h1122_3344) begin
        errors++; $display("FAIL idle_ack_%0d got cyc %0h stall %0h ld %h exp 0 0 11223344", i, wb_cyc_o, mem_stall, load_data);
      end
    end
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 1'b0;
    addr = 32'h0; wdata = 32'h0; advance = 1'b0; wb_dat_i = 32'h0; wb_ack_i = 1'b0;
    tick();
    tick();
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_hold_done();
    test_rw_and_idle_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
